// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and the round-robin pick function for mem_arbiter.
package mem_arb_pkg;
    localparam int ARB_MAX_REQ = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;
    // First set bit of req[n-1:0] scanning upward from ptr, wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] req, input int unsigned ptr,
                                         input int unsigned n);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int i = ARB_MAX_REQ - 1; i >= 0; i--) begin
            j = (ptr + unsigned'(i)) % n;
            if (unsigned'(i) < n && req[j[4:0]]) begin
                r.found = 1'b1;
                r.idx   = j[4:0];
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_priority_pick.sv
// rr_priority_pick: rotate requests by ptr, priority-encode, rotate the index back.
module rr_priority_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);
    logic [NUM_REQ-1:0] rot;
    rr_pick_t           p;
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rot[i] = req[IW'((i + int'(ptr)) % NUM_REQ)];
    end
    assign p     = rr_pick(ARB_MAX_REQ'(rot), 0, NUM_REQ);
    assign found = p.found;
    assign idx   = IW'((32'(p.idx) + 32'(ptr)) % NUM_REQ);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one RAM port among NUM_REQ cores.
// Optional MEM_ARB_PERF_EN adds per-core grant counters and a stall counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RD_LAT  = 1,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          c_req,
    input  logic [NUM_REQ-1:0]          c_we,
    input  logic [NUM_REQ-1:0][AW-1:0]  c_addr,
    input  logic [NUM_REQ-1:0][DW-1:0]  c_wdata,
    output logic [NUM_REQ-1:0]          c_gnt,
    output logic [NUM_REQ-1:0]          c_rvalid,
    output logic [DW-1:0]               c_rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    input  logic [DW-1:0]               mem_rdata,
    output logic                        busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][31:0]    perf_gnt_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);
    arb_state_e    state, nxt;
    logic [IW-1:0] rr_ptr, win, pick_idx;
    logic          pick_found;
    logic [CW-1:0] cnt;

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (c_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            win       <= '0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            c_rdata   <= '0;
        end else begin
            state <= nxt;
            if (state == ARB_IDLE && pick_found) begin
                win       <= pick_idx;
                mem_we    <= c_we[pick_idx];
                mem_addr  <= c_addr[pick_idx];
                mem_wdata <= c_wdata[pick_idx];
            end
            if (state == ARB_ISSUE) begin
                rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
                cnt    <= CW'(RD_LAT - 1);
            end
            if (state == ARB_WAIT) begin
                cnt <= (cnt == '0) ? cnt : cnt - CW'(1);
                if (cnt == '0) c_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        nxt      = state;
        mem_req  = 1'b0;
        c_gnt    = '0;
        c_rvalid = '0;
        case (state)
            ARB_IDLE:  nxt = pick_found ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: begin
                nxt     = mem_we ? ARB_IDLE : ARB_WAIT;
                mem_req = 1'b1;
                c_gnt   = NUM_REQ'(1) << win;
            end
            ARB_WAIT:  nxt = (cnt == '0) ? ARB_RESP : ARB_WAIT;
            default: begin
                nxt      = ARB_IDLE;
                c_rvalid = NUM_REQ'(1) << win;
            end
        endcase
    end

    assign busy = state != ARB_IDLE;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_gnt_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                perf_gnt_cnt[i] <= perf_gnt_cnt[i] + 32'(c_gnt[i]);
            perf_stall_cnt <= perf_stall_cnt + 32'(|(c_req & ~c_gnt));
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter (RD_LAT=3) with a RAM latency model.
module tb_mem_arbiter;
    localparam int N = 4;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      c_req = '0, c_we = '0;
    logic [N-1:0][31:0] c_addr = '0, c_wdata = '0;
    logic [N-1:0]      c_gnt, c_rvalid;
    logic [31:0]       c_rdata, mem_addr, mem_wdata, mem_rdata;
    logic              mem_req, mem_we, busy;
`ifdef MEM_ARB_PERF_EN
    logic [N-1:0][31:0] perf_gnt_cnt;
    logic [31:0]        perf_stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    mem_arbiter #(.NUM_REQ(N), .AW(32), .DW(32), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef MEM_ARB_PERF_EN
        , .perf_gnt_cnt(perf_gnt_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: read data valid only exactly RD_LAT cycles after a read mem_req.
    logic [RD_LAT-1:0]       pv;
    logic [RD_LAT-1:0][31:0] pa;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            pa <= '0;
        end else begin
            pv <= {pv[RD_LAT-2:0], mem_req & ~mem_we};
            pa <= {pa[RD_LAT-2:0], mem_addr};
        end
    end
    assign mem_rdata = !pv[RD_LAT-1] ? 32'hBAD0BAD0 :
                       (pa[RD_LAT-1] == 32'h40) ? 32'h12345678 : (pa[RD_LAT-1] ^ 32'hA5A50000);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        c_req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g);
        int n = 0;
        while (c_gnt == '0 && n < 20) begin
            step();
            n++;
        end
        g = c_gnt;
    endtask

    task automatic wait_rvalid(output logic [N-1:0] v);
        int n = 0;
        while (c_rvalid == '0 && n < 20) begin
            step();
            n++;
        end
        v = c_rvalid;
    endtask

    task automatic test_single_write;
        c_we[2] = 1'b1;
        c_addr[2] = 32'h100;
        c_wdata[2] = 32'hDEADBEEF;
        c_req = 4'b0100;
        checks++; if (c_gnt !== 4'b0000) begin errors++; $display("FAIL wr_gnt_early: got %b want 0000", c_gnt); end
        step();
        checks++; if (c_gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt: got %b want 0100", c_gnt); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL wr_mem_req: got %b want 1", mem_req); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL wr_addr: got %h want 00000100", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
        c_req = '0;
        step();
        checks++; if ({c_gnt, mem_req, busy} !== 6'b0) begin errors++; $display("FAIL wr_idle: gnt=%b req=%b busy=%b want 0", c_gnt, mem_req, busy); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL wr_addr_hold: got %h want 00000100", mem_addr); end
    endtask

    task automatic test_single_read;
        c_we[1] = 1'b0;
        c_addr[1] = 32'h40;
        c_req = 4'b0010;
        step();
        checks++; if (c_gnt !== 4'b0010 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_gnt: gnt=%b we=%b want 0010/0", c_gnt, mem_we); end
        c_req = '0;
        for (int k = 1; k <= RD_LAT; k++) begin
            step();
            checks++; if (c_rvalid !== 4'b0 || c_gnt !== 4'b0) begin errors++; $display("FAIL rd_wait%0d: rvalid=%b gnt=%b want 0", k, c_rvalid, c_gnt); end
        end
        step();
        checks++; if (c_rvalid !== 4'b0010) begin errors++; $display("FAIL rd_rvalid: got %b want 0010", c_rvalid); end
        checks++; if (c_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h want 12345678", c_rdata); end
        step();
        checks++; if (c_rvalid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_done: rvalid=%b busy=%b want 0", c_rvalid, busy); end
        checks++; if (c_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_hold: got %h want 12345678", c_rdata); end
    endtask

    task automatic test_reset;
        c_we[1] = 1'b0;
        c_addr[1] = 32'h44;
        c_req = 4'b0010;
        step();
        checks++; if (c_gnt !== 4'b0010) begin errors++; $display("FAIL rst_pre_gnt: got %b want 0010", c_gnt); end
        c_req = '0;
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if ({c_gnt, c_rvalid, mem_req, mem_we, busy} !== 11'b0) begin errors++; $display("FAIL rst_ctrl: gnt=%b rv=%b req=%b we=%b busy=%b want 0", c_gnt, c_rvalid, mem_req, mem_we, busy); end
        checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", c_rdata); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem: addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if ({c_gnt, c_rvalid, busy} !== 9'b0) begin errors++; $display("FAIL rst_after%0d: gnt=%b rv=%b busy=%b want 0", k, c_gnt, c_rvalid, busy); end
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] g;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            c_we[i] = 1'b1;
            c_addr[i] = 32'h1000 + 32'(i * 4);
        end
        c_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_gnt(g);
            checks++; if (g !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_order%0d: got %b want %b", k, g, 4'b0001 << (k % 4)); end
            checks++; if (mem_addr !== 32'h1000 + 32'((k % 4) * 4)) begin errors++; $display("FAIL rr_addr%0d: got %h want %h", k, mem_addr, 32'h1000 + 32'((k % 4) * 4)); end
            step();
        end
        c_req = '0;
        step();
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] g, v;
        apply_reset();
        c_we[3] = 1'b1;
        c_addr[3] = 32'h300;
        c_wdata[3] = 32'h33;
        c_req = 4'b1000;
        wait_gnt(g);
        checks++; if (g !== 4'b1000 || mem_we !== 1'b1) begin errors++; $display("FAIL b2b_wr: gnt=%b we=%b want 1000/1", g, mem_we); end
        c_we[3] = 1'b0;
        c_addr[3] = 32'h80;
        c_we[0] = 1'b1;
        c_addr[0] = 32'h200;
        c_req = 4'b1001;
        step();
        wait_gnt(g);
        checks++; if (g !== 4'b0001 || mem_addr !== 32'h200) begin errors++; $display("FAIL b2b_core0: gnt=%b addr=%h want 0001/00000200", g, mem_addr); end
        c_req[0] = 1'b0;
        step();
        wait_gnt(g);
        checks++; if (g !== 4'b1000 || mem_we !== 1'b0 || mem_addr !== 32'h80) begin errors++; $display("FAIL b2b_rd: gnt=%b we=%b addr=%h want 1000/0/00000080", g, mem_we, mem_addr); end
        c_req = '0;
        wait_rvalid(v);
        checks++; if (v !== 4'b1000 || c_rdata !== 32'hA5A50080) begin errors++; $display("FAIL b2b_rdata: rv=%b data=%h want 1000/a5a50080", v, c_rdata); end
        step();
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf;
        logic [N-1:0] g;
        apply_reset();
        checks++; if (perf_gnt_cnt !== '0 || perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL perf_reset: gnt=%h stall=%h want 0", perf_gnt_cnt, perf_stall_cnt); end
        c_we = 4'b0011;
        c_req = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            wait_gnt(g);
            if (k == 7) c_req = 4'b0001;
            if (k == 11) c_req = 4'b0000;
            step();
        end
        step();
        checks++; if (perf_gnt_cnt[0] !== 32'd8) begin errors++; $display("FAIL perf_core0: got %0d want 8", perf_gnt_cnt[0]); end
        checks++; if (perf_gnt_cnt[1] !== 32'd4) begin errors++; $display("FAIL perf_core1: got %0d want 4", perf_gnt_cnt[1]); end
        checks++; if (perf_gnt_cnt[2] !== 32'd0 || perf_gnt_cnt[3] !== 32'd0) begin errors++; $display("FAIL perf_core23: got %0d/%0d want 0/0", perf_gnt_cnt[2], perf_gnt_cnt[3]); end
        checks++; if (perf_stall_cnt === 32'd0) begin errors++; $display("FAIL perf_stall: got 0 want nonzero"); end
    endtask
`endif

    initial begin
        apply_reset();
        test_single_write();
        test_single_read();
        test_reset();
        test_round_robin();
        test_back_to_back();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
